// File: rtl/galaksija_pkg.sv
// Shared types and tape-level encoding for the Galaksija cassette player.
// One byte on tape is 8 bits (LSB first), each bit split into 8 sub-phases.
package galaksija_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_PLAY  = 2'd3
    } tape_state_e;

    localparam logic [2:0] SUB_START   = 3'd0;
    localparam logic [2:0] SUB_DATA    = 3'd4;
    localparam logic [2:0] SUB_LAST    = 3'd7;
    localparam logic [2:0] BIT_LAST    = 3'd7;
    localparam logic       LEVEL_IDLE  = 1'b1;
    localparam logic       LEVEL_PULSE = 1'b0;

    // Every bit starts with a sync pulse; a '1' bit adds a second pulse mid-bit.
    function automatic logic sub_level(input logic [2:0] sub, input logic data_bit);
        logic lvl;
        lvl = LEVEL_IDLE;
        if (sub == SUB_START) begin
            lvl = LEVEL_PULSE;
        end else if ((sub == SUB_DATA) && data_bit) begin
            lvl = LEVEL_PULSE;
        end else begin
            lvl = LEVEL_IDLE;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/galaksija_tape_timer.sv
// Tick divider for one tape sub-phase; terminal count is SUB_TICKS or, for the
// inter-byte gap, GAP_TICKS enabled ticks.
module galaksija_tape_timer #(
    parameter int SUB_TICKS = 1152,
    parameter int GAP_TICKS = 13002
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic tick_en_i,
    input  logic gap_sel_i,
    output logic done_o
);
    localparam int MAX_TICKS = (GAP_TICKS > SUB_TICKS) ? GAP_TICKS : SUB_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] SUB_LAST_CNT = CNT_W'(SUB_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST_CNT = CNT_W'(GAP_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_cnt;

    assign last_cnt = gap_sel_i ? GAP_LAST_CNT : SUB_LAST_CNT;
    assign done_o   = tick_en_i && (cnt_q == last_cnt);

    // Next tick count: cleared outside playback, wraps at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_en_i) begin
            if (done_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Tick counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/galaksija_tape_player.sv
// Replays a downloaded cassette image from SDRAM as a Galaksija tape signal.
// Playback (re)starts on every falling edge of load_active.
module galaksija_tape_player
    import galaksija_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int SUB_TICKS = 1152,
    parameter int GAP_TICKS = 13002
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              load_active,
    input  logic              load_wr,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [7:0]        rd_data,
    input  logic              abort,
    output logic              tape_bit,
    output logic              playing,
    output logic [ADDR_W-1:0] addr_max,
    output logic [ADDR_W-1:0] byte_pos
);
    tape_state_e       state_q, state_d;
    logic              load_active_q;
    logic [ADDR_W-1:0] addr_max_q, addr_max_d;
    logic [ADDR_W-1:0] byte_pos_q, byte_pos_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              tape_bit_q, tape_bit_d;
    logic              playing_q, playing_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        sub_q, sub_d;
    logic [7:0]        data_q, data_d;

    logic              start_edge;
    logic              sub_done;
    logic [2:0]        next_bit;
    logic [2:0]        next_sub;

    assign start_edge = load_active_q && !load_active;
    assign next_bit   = bit_q + 3'd1;
    assign next_sub   = sub_q + 3'd1;

    galaksija_tape_timer #(
        .SUB_TICKS (SUB_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != ST_PLAY),
        .tick_en_i (ce && (state_q == ST_PLAY)),
        .gap_sel_i ((bit_q == BIT_LAST) && (sub_q == SUB_LAST)),
        .done_o    (sub_done)
    );

    // Next-state and registered-output logic; start beats abort beats normal flow.
    always_comb begin
        state_d    = state_q;
        addr_max_d = addr_max_q;
        byte_pos_d = byte_pos_q;
        rd_req_d   = rd_req_q;
        rd_addr_d  = rd_addr_q;
        tape_bit_d = tape_bit_q;
        bit_d      = bit_q;
        sub_d      = sub_q;
        data_d     = data_q;

        if (load_active && load_wr) begin
            addr_max_d = load_addr;
        end else begin
            addr_max_d = addr_max_q;
        end

        if (start_edge) begin
            state_d    = ST_FETCH;
            byte_pos_d = '0;
            rd_req_d   = 1'b0;
            tape_bit_d = LEVEL_IDLE;
            bit_d      = 3'd0;
            sub_d      = 3'd0;
        end else if (abort) begin
            state_d    = ST_IDLE;
            rd_req_d   = 1'b0;
            tape_bit_d = LEVEL_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rd_req_d   = 1'b0;
                    tape_bit_d = LEVEL_IDLE;
                end
                ST_FETCH: begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = byte_pos_q;
                    state_d   = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd_ack) begin
                        data_d     = rd_data;
                        rd_req_d   = 1'b0;
                        bit_d      = 3'd0;
                        sub_d      = 3'd0;
                        tape_bit_d = sub_level(SUB_START, rd_data[0]);
                        state_d    = ST_PLAY;
                    end else begin
                        rd_req_d = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (!sub_done) begin
                        sub_d = sub_q;
                    end else if (sub_q != SUB_LAST) begin
                        sub_d      = next_sub;
                        tape_bit_d = sub_level(next_sub, data_q[bit_q]);
                    end else if (bit_q != BIT_LAST) begin
                        bit_d      = next_bit;
                        sub_d      = SUB_START;
                        tape_bit_d = sub_level(SUB_START, data_q[next_bit]);
                    end else begin
                        // End of byte; the all-ones guard keeps byte_pos from wrapping
                        // if addr_max was rewritten below it mid-playback.
                        bit_d      = 3'd0;
                        sub_d      = 3'd0;
                        tape_bit_d = LEVEL_IDLE;
                        if ((byte_pos_q == addr_max_q) || (&byte_pos_q)) begin
                            state_d = ST_IDLE;
                        end else begin
                            byte_pos_d = byte_pos_q + ADDR_W'(1);
                            state_d    = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    rd_req_d   = 1'b0;
                    tape_bit_d = LEVEL_IDLE;
                end
            endcase
        end

        playing_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            load_active_q <= 1'b0;
            addr_max_q    <= '0;
            byte_pos_q    <= '0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            tape_bit_q    <= LEVEL_IDLE;
            playing_q     <= 1'b0;
            bit_q         <= 3'd0;
            sub_q         <= 3'd0;
            data_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            load_active_q <= load_active;
            addr_max_q    <= addr_max_d;
            byte_pos_q    <= byte_pos_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            tape_bit_q    <= tape_bit_d;
            playing_q     <= playing_d;
            bit_q         <= bit_d;
            sub_q         <= sub_d;
            data_q        <= data_d;
        end
    end

    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign tape_bit = tape_bit_q;
    assign playing  = playing_q;
    assign addr_max = addr_max_q;
    assign byte_pos = byte_pos_q;

endmodule

// File: tb/tb_galaksija_tape_player.sv
// Self-checking bench for galaksija_tape_player: directed scenarios plus random
// images, checked tick-by-tick against a waveform model of the tape format.
module tb_galaksija_tape_player;
    localparam int ADDR_W   = 8;
    localparam int SUB_T    = 4;
    localparam int GAP_T    = 10;
    localparam int BYTE_LEN = 63 * SUB_T + GAP_T;

    logic              clk = 1'b0;
    logic              reset, ce, load_active, load_wr, rd_ack, abort;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        rd_data;
    logic              rd_req, tape_bit, playing;
    logic [ADDR_W-1:0] rd_addr, addr_max, byte_pos;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         ce_mode = 0;
    logic [7:0] mem [0:255];

    galaksija_tape_player #(
        .ADDR_W    (ADDR_W),
        .SUB_TICKS (SUB_T),
        .GAP_TICKS (GAP_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .load_active (load_active),
        .load_wr     (load_wr),
        .load_addr   (load_addr),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .abort       (abort),
        .tape_bit    (tape_bit),
        .playing     (playing),
        .addr_max    (addr_max),
        .byte_pos    (byte_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_ce();
        case (ce_mode)
            0:       ce = 1'b1;
            1:       ce = ((cyc % 3) == 0);
            default: ce = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Expected level t enabled ticks after a byte starts playing.
    function automatic logic exp_level(input logic [7:0] b, input int t);
        int k, s, bi;
        k = t / SUB_T;
        if (k > 63) k = 63;
        s  = k % 8;
        bi = k / 8;
        if (s == 0) return 1'b0;
        if ((s == 4) && b[bi]) return 1'b0;
        return 1'b1;
    endfunction

    // Writes bytes 0..n-1 (already in mem) and leaves load_active low so the next edge starts playback.
    task automatic load_image(input int n);
        load_active = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            load_wr   = 1'b1;
            load_addr = ADDR_W'(i);
            tick();
        end
        load_wr = 1'b0;
        chk("addr_max_loaded", addr_max, n - 1);
        load_active = 1'b0;
    endtask

    // Plays n bytes from the start edge, serving reads after 'delay' cycles.
    task automatic play(input int n, input int delay, input int stop_byte, input int stop_t,
                        output bit stopped);
        int   phase, idx, t, cnt, falls, budget;
        logic prev, ce_app, ack_app;
        phase = 0; idx = 0; t = 0; cnt = 0; falls = 0; prev = 1'b1;
        stopped = 1'b0;
        budget = n * (BYTE_LEN * 4 + delay + 20) + 20;
        drive_ce();
        for (int c = 0; c < budget && phase != 3 && !stopped; c++) begin
            ce_app  = ce;
            ack_app = rd_ack;
            tick();
            rd_ack = 1'b0;
            if (phase == 2 && ce_app) t++;
            if (ack_app) begin
                phase = 2; t = 0; falls = 0; prev = 1'b1;
            end
            if (phase == 2) begin
                if (t == BYTE_LEN) begin
                    chk("pulse_count", falls, 8 + $countones(mem[idx]));
                    if (idx == n - 1) begin
                        phase = 3;
                        chk("end_playing", playing, 0);
                        chk("end_tape", tape_bit, 1);
                        chk("end_req", rd_req, 0);
                        chk("end_pos", byte_pos, n - 1);
                    end else begin
                        idx++;
                        phase = 0;
                        chk("next_pos", byte_pos, idx);
                    end
                end else begin
                    if (tape_bit == 1'b0 && prev == 1'b1) falls++;
                    prev = tape_bit;
                    chk("tape_bit", tape_bit, exp_level(mem[idx], t));
                    chk("play_req", rd_req, 0);
                    chk("play_active", playing, 1);
                    if (idx == stop_byte && t == stop_t) stopped = 1'b1;
                end
            end
            if (phase == 0) begin
                chk("fetch_tape", tape_bit, 1);
                chk("fetch_playing", playing, 1);
                if (rd_req) begin
                    chk("rd_addr", rd_addr, idx);
                    phase = 1;
                    cnt = 0;
                end
            end
            if (phase == 1) begin
                chk("hold_req", rd_req, 1);
                chk("hold_addr", rd_addr, idx);
                chk("hold_tape", tape_bit, 1);
                cnt++;
                if (cnt == delay) begin
                    rd_ack  = 1'b1;
                    rd_data = mem[idx];
                end
            end
            if (phase != 3 && !stopped) drive_ce();
        end
        if (phase != 3 && !stopped) chk("timeout", phase, 3);
    endtask

    initial begin
        bit stopped;
        int n;
        reset = 1'b1; ce = 1'b1; load_active = 1'b0; load_wr = 1'b0; load_addr = '0;
        rd_ack = 1'b0; rd_data = 8'd0; abort = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_tape", tape_bit, 1);
        chk("rst_req", rd_req, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_playing", playing, 0);
        chk("rst_pos", byte_pos, 0);
        chk("rst_max", addr_max, 0);

        // Reference image: one pulse per bit, two per bit, then a mixed pattern.
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'hA5;
        ce_mode = 0; load_image(3); play(3, 2, -1, -1, stopped);
        ce_mode = 1; load_image(3); play(3, 2, -1, -1, stopped);
        ce_mode = 0; load_image(3); play(3, 20, -1, -1, stopped);

        // load_wr without load_active must not move addr_max.
        load_wr = 1'b1; load_addr = 8'd77;
        tick();
        load_wr = 1'b0;
        chk("wr_ignored", addr_max, 2);

        // Abort during byte 1, then restart from byte 0.
        load_image(3); play(3, 2, 1, 100, stopped);
        chk("abort_reached", stopped, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_playing", playing, 0);
        chk("abort_tape", tape_bit, 1);
        chk("abort_req", rd_req, 0);
        chk("abort_pos", byte_pos, 1);
        repeat (5) tick();
        chk("abort_stays_idle", playing, 0);
        load_active = 1'b1; tick(); load_active = 1'b0;
        play(3, 3, -1, -1, stopped);

        // Reload mid byte 1 with a shorter image: restart at byte 0 with the new addr_max.
        load_image(3); play(3, 2, 1, 40, stopped);
        chk("reload_reached", stopped, 1);
        mem[0] = 8'h3C; mem[1] = 8'h81;
        load_image(2); play(2, 2, -1, -1, stopped);

        // Randomized images, ce patterns and read latencies; round 0 is the single-byte case.
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? 1 : int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
            ce_mode = int'($urandom_range(0, 2));
            load_image(n);
            play(n, int'($urandom_range(1, 6)), -1, -1, stopped);
        end

        // Reset together with abort, a start edge and a load write, mid-playback.
        ce_mode = 0;
        load_image(2); play(2, 2, 0, 50, stopped);
        chk("reset_reached", stopped, 1);
        load_active = 1'b1;
        tick();
        reset = 1'b1; abort = 1'b1; load_active = 1'b0; load_wr = 1'b1; load_addr = 8'd99;
        tick();
        chk("rst2_tape", tape_bit, 1);
        chk("rst2_req", rd_req, 0);
        chk("rst2_addr", rd_addr, 0);
        chk("rst2_playing", playing, 0);
        chk("rst2_pos", byte_pos, 0);
        chk("rst2_max", addr_max, 0);
        reset = 1'b0; abort = 1'b0; load_wr = 1'b0;
        repeat (3) tick();
        chk("rst2_idle", playing, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/galaksija_tape_player.md
GALAKSIJA_TAPE_PLAYER -- requirements
Module: galaksija_tape_player

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the tape buffer byte-address width.
REQ-002 Parameter SUB_TICKS, default 1152, SHALL set the enabled ticks per bit sub-phase.
REQ-003 Parameter GAP_TICKS, default 13002, SHALL set the enabled ticks of the final sub-phase of each byte.
REQ-004 Ports: clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-005 Ports: ce in 1 tick enable (speed-corrected clock); load_active in 1 image download in progress; load_wr in 1 download byte strobe; load_addr in ADDR_W download byte address.
REQ-006 Ports: rd_req out 1 SDRAM read request; rd_addr out ADDR_W read address; rd_ack in 1 read-data-valid pulse; rd_data in 8 read byte.
REQ-007 Ports: abort in 1 stop playback (BREAK); tape_bit out 1 cassette level; playing out 1 playback active; addr_max out ADDR_W last loaded address; byte_pos out ADDR_W current byte index (progress bar).

Function
REQ-008 Every load_wr while load_active is high SHALL set addr_max to load_addr.
REQ-009 A falling edge of load_active SHALL start playback from byte 0 in any state, including mid-playback.
REQ-010 States SHALL be IDLE, FETCH, WAIT, PLAY.
REQ-011 IDLE: playing=0, tape_bit=1, rd_req=0; the only exit is the start edge of REQ-009, to FETCH.
REQ-012 FETCH: assert rd_req with rd_addr=byte_pos, then go to WAIT.
REQ-013 WAIT: hold rd_req=1 and rd_addr stable until rd_ack, then latch rd_data, clear rd_req on the next edge, reset bit and sub-phase counters to 0, and go to PLAY. This state SHALL NOT be gated by ce.
REQ-014 PLAY: a 3-bit bit index (LSB first) and a 3-bit sub-phase SHALL advance only on cycles with ce=1.
REQ-015 Each sub-phase SHALL last SUB_TICKS enabled ticks, except sub-phase 7 of bit 7, which SHALL last GAP_TICKS.
REQ-016 tape_bit SHALL be 0 in sub-phase 0, 0 in sub-phase 4 when the current bit is 1, and 1 otherwise; it SHALL be registered and change on the edge that enters the sub-phase.
REQ-017 At the end of bit 7, sub-phase 7: if byte_pos == addr_max, go to IDLE. Otherwise increment byte_pos and go to FETCH.
REQ-018 The addr_max compare SHALL be unsigned over ADDR_W bits, and byte_pos SHALL never wrap.
REQ-019 If addr_max is 0 at start, exactly one byte SHALL be played.
REQ-020 abort=1 SHALL go to IDLE on the next edge, with tape_bit=1 and rd_req=0. A start edge in the same cycle as abort SHALL win.
REQ-021 With ce=0, PLAY SHALL freeze all counters and tape_bit.
REQ-022 playing SHALL be 1 in FETCH, WAIT and PLAY.

Reset
REQ-023 Reset SHALL leave: state IDLE, tape_bit=1, rd_req=0, rd_addr=0, playing=0, byte_pos=0, addr_max=0, all counters 0, latched byte 0.
REQ-024 Reset SHALL take priority over start, abort and load_wr in the same cycle.

Structure
REQ-025 The state enum and the tape_bit sub-phase encoding constants SHALL live in the shared package galaksija_pkg.
REQ-026 The tick divider (sub-phase counter with a SUB/GAP terminal-count select) SHALL be the sub-module galaksija_tape_timer. All else stays flat.

Verification
REQ-027 Load 3 bytes {0x00,0xFF,0xA5} (addr 0..2), drop load_active, ce=1, SUB_TICKS=4, GAP_TICKS=10, rd_ack 2 cycles after rd_req. Required: addr_max=2, three rd_req pulses at addr 0,1,2. Byte 0x00 gives one low pulse per bit; 0xFF gives two per bit; 0xA5 gives the LSB-first bit pattern 1,0,1,0,0,1,0,1. Then playing=0, tape_bit=1.
REQ-028 Same setup with ce toggling 1-in-3: every tape_bit interval is 3x longer, and the sequence is identical.
REQ-029 rd_ack delayed 20 cycles: rd_req and rd_addr stay stable for all 20, and tape_bit holds 1 until the data is latched.
REQ-030 abort asserted during byte 1: IDLE next edge, tape_bit=1, byte_pos retained. A later load_active fall restarts at byte 0.
REQ-031 load_active pulse (high then low) mid-playback of byte 1: playback restarts at byte 0 with the new addr_max.
REQ-032 Reset asserted mid-PLAY together with abort and a start edge: all outputs take the REQ-023 values on the next edge.
